// File: rtl/q_event_buffer_pkg.sv
// q_event_buffer shared definitions: width defaults and event-word layout.
// The readout decoder slices words with MASK_LSB / TS_LSB / EVT_WIDTH.
package q_event_buffer_pkg;

    localparam int Q_WIDTH_D    = 31;
    localparam int TS_WIDTH_D   = 32;
    localparam int NCH_D        = 4;
    localparam int DEPTH_LOG2_D = 4;

    // Event word = {mask, ts, Q}, MSB first.
    localparam int TS_LSB    = Q_WIDTH_D;
    localparam int MASK_LSB  = TS_WIDTH_D + Q_WIDTH_D;
    localparam int EVT_WIDTH = NCH_D + MASK_LSB;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/q_event_buffer_sync_fifo.sv
// Synchronous FIFO with registered read port and registered count/full/empty.
// Ports: clk, rst (sync, active-high), wr_en/wr_data, rd_en -> rd_data/rd_valid, empty, full, count.
module q_event_buffer_sync_fifo
    import q_event_buffer_pkg::*;
#(
    parameter int WIDTH      = EVT_WIDTH,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    rd_nxt;
    logic             do_wr;
    logic             do_rd;

    // full/empty are pre-cycle flags, so a read never frees room
    // for a same-cycle write, and a write never feeds a same-cycle read.
    always_comb begin
        do_wr  = wr_en & ~full;
        do_rd  = rd_en & ~empty;
        wr_nxt = wr_ptr + PW'(do_wr);
        rd_nxt = rd_ptr + PW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            count    <= wr_nxt - rd_nxt;
            empty    <= (wr_nxt == rd_nxt);
            // Same slot, opposite wrap bit: one full lap ahead.
            full     <= (wr_nxt[PW-1] != rd_nxt[PW-1])
                     && (wr_nxt[PW-2:0] == rd_nxt[PW-2:0]);
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr[PW-2:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem[wr_ptr[PW-2:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/q_event_buffer.sv
// Q event buffer: tags each Q with trigger timestamp and ToT mask, buffers in a FIFO.
// Ports: clk, RESET, Q_in/Q_valid_in, tot_in, rd_en -> rd_data/rd_valid, empty/full/count, drop_count, clear_drops.
module q_event_buffer
    import q_event_buffer_pkg::*;
#(
    parameter int Q_WIDTH    = Q_WIDTH_D,
    parameter int TS_WIDTH   = TS_WIDTH_D,
    parameter int NCH        = NCH_D,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_D
) (
    input  logic                            clk,
    input  logic                            RESET,
    input  logic [Q_WIDTH-1:0]              Q_in,
    input  logic                            Q_valid_in,
    input  logic [NCH-1:0]                  tot_in,
    input  logic                            rd_en,
    output logic [NCH+TS_WIDTH+Q_WIDTH-1:0] rd_data,
    output logic                            rd_valid,
    output logic                            empty,
    output logic                            full,
    output logic [DEPTH_LOG2:0]             count,
    output logic [15:0]                     drop_count,
    input  logic                            clear_drops
);

    localparam int W = NCH + TS_WIDTH + Q_WIDTH;

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_lat;
    logic [NCH-1:0]      acc_mask;
    logic                armed;
    logic                trig_q;
    logic                any_trig;
    logic                trig_rise;
    logic [W-1:0]        word;

    // Mask includes this cycle's bits; ts falls back to the capture
    // cycle when no trigger edge preceded the strobe.
    always_comb begin
        any_trig  = |tot_in;
        trig_rise = any_trig & ~trig_q;
        word      = {acc_mask | tot_in, armed ? ts : ts_lat, Q_in};
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            ts       <= '0;
            ts_lat   <= '0;
            acc_mask <= '0;
            armed    <= 1'b1;
            trig_q   <= 1'b0;
        end else begin
            ts     <= ts + TS_WIDTH'(1);
            trig_q <= any_trig;
            unique case (1'b1)
                Q_valid_in: begin
                    // Same-cycle edge already belongs to this word.
                    acc_mask <= '0;
                    armed    <= 1'b1;
                end
                default: begin
                    acc_mask <= acc_mask | tot_in;
                    if (armed && trig_rise) begin
                        ts_lat <= ts;
                        armed  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            drop_count <= '0;
        end else if (clear_drops) begin
            drop_count <= '0;
        end else if (Q_valid_in && full && drop_count != DROP_MAX) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    q_event_buffer_sync_fifo #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (RESET),
        .wr_en    (Q_valid_in),
        .wr_data  (word),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

endmodule

// File: tb/tb_q_event_buffer.sv
// Scoreboard bench for q_event_buffer: directed tagging, overflow, read and reset cases.
// A narrow-timestamp second instance exercises timestamp wrap.
`timescale 1ns/1ps
module tb_q_event_buffer;
    import q_event_buffer_pkg::*;

    typedef logic [EVT_WIDTH-1:0] word_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [30:0] Q_in = '0;
    logic        Q_valid_in = 1'b0;
    logic [3:0]  tot_in = '0;
    logic        rd_en = 1'b0;
    logic        clear_drops = 1'b0;
    word_t       rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic [15:0] drop_count;

    logic        w_valid = 1'b0;
    logic        w_rd = 1'b0;
    logic [37:0] w_rd_data;
    logic        w_rd_valid;
    logic        w_empty;
    logic        w_full;
    logic [2:0]  w_count;
    logic [15:0] w_drops;

    always #8 clk = ~clk;

    q_event_buffer dut (
        .clk         (clk),
        .RESET       (RESET),
        .Q_in        (Q_in),
        .Q_valid_in  (Q_valid_in),
        .tot_in      (tot_in),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .drop_count  (drop_count),
        .clear_drops (clear_drops)
    );

    q_event_buffer #(
        .TS_WIDTH   (3),
        .DEPTH_LOG2 (2)
    ) u_wrap (
        .clk         (clk),
        .RESET       (RESET),
        .Q_in        (Q_in),
        .Q_valid_in  (w_valid),
        .tot_in      (tot_in),
        .rd_en       (w_rd),
        .rd_data     (w_rd_data),
        .rd_valid    (w_rd_valid),
        .empty       (w_empty),
        .full        (w_full),
        .count       (w_count),
        .drop_count  (w_drops),
        .clear_drops (1'b0)
    );

    // Cycle index equals the DUT timestamp while sampled at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= RESET ? 0 : cyc + 1;

    word_t mq[$];
    word_t sb[$];
    word_t last_rd = '0;
    int    errors = 0;
    int    checks = 0;
    int    exp_drops = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; the reference FIFO decides what the
    // DUT must return and pushes it onto the scoreboard.
    task automatic step(input bit wv, input logic [30:0] q,
                        input logic [3:0] m, input logic [31:0] t,
                        input bit re);
        word_t w;
        bit    full_pre;
        w = {m, t, q};
        full_pre = (mq.size() == 16);
        Q_valid_in = wv;
        Q_in = q;
        rd_en = re;
        if (re && mq.size() > 0) begin
            last_rd = mq.pop_front();
            sb.push_back(last_rd);
        end
        if (wv) begin
            if (!full_pre) mq.push_back(w);
            else if (exp_drops < 65535) exp_drops++;
        end
        @(negedge clk);
        Q_valid_in = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        Q_valid_in = 1'b0;
        rd_en = 1'b0;
        tot_in = '0;
        clear_drops = 1'b0;
        mq.delete();
        exp_drops = 0;
        last_rd = '0;
        @(negedge clk);
        RESET = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        word_t e;
        if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_word: got %h want no read", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_word: got %h want %h", rd_data, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chkw("rst_rd_data", rd_data, '0);
        chk("rst_drops", 32'(drop_count), 0);
        chk("rst_count", 32'(count), 0);

        // Trigger tagging
        wait_cyc(10);
        tot_in = 4'b0010;
        wait_cyc(12);
        tot_in = 4'b0110;
        @(negedge clk);
        tot_in = 4'b0010;
        wait_cyc(20);
        step(1, 31'd1234, 4'b0110, 32'd10, 0);
        tot_in = '0;
        chk("cap_empty", 32'(empty), 0);
        wait_cyc(25);
        step(0, '0, '0, '0, 1);
        chk("tag_rd_valid", 32'(rd_valid), 1);

        // Untriggered capture
        do_reset();
        wait_cyc(5);
        step(1, 31'd7, 4'b0000, 32'd5, 0);
        chk("untrig_count", 32'(count), 1);
        step(0, '0, '0, '0, 1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 31'(100 + i), 4'b0, 32'(cyc), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        for (int i = 0; i < 3; i++) begin
            step(1, 31'(300 + i), 4'b0, 32'(cyc), 0);
        end
        chk("ovf_drops", 32'(drop_count), 3);
        chk("ovf_count", 32'(count), 16);
        clear_drops = 1'b1;
        @(negedge clk);
        clear_drops = 1'b0;
        chk("clear_drops", 32'(drop_count), 0);

        // Full with simultaneous read and write
        step(1, 31'd555, 4'b0, 32'(cyc), 1);
        chk("rw_full_drops", 32'(drop_count), 1);
        chk("rw_full_count", 32'(count), 15);
        chk("rw_full_flag", 32'(full), 0);
        repeat (15) step(0, '0, '0, '0, 1);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Read while empty
        step(0, '0, '0, '0, 1);
        chk("rd_empty_valid", 32'(rd_valid), 0);
        chkw("rd_empty_hold", rd_data, last_rd);

        // Empty FIFO, simultaneous write and read
        step(1, 31'd9, 4'b0, 32'(cyc), 1);
        chk("wr_rd_empty_count", 32'(count), 1);
        chk("wr_rd_empty_valid", 32'(rd_valid), 0);
        step(0, '0, '0, '0, 1);

        // Reset mid-operation with an armed latch pending
        for (int i = 0; i < 5; i++) begin
            step(1, 31'(200 + i), 4'b0, 32'(cyc), 0);
        end
        tot_in = 4'b0001;
        @(negedge clk);
        RESET = 1'b1;
        Q_valid_in = 1'b1;
        Q_in = 31'd99;
        tot_in = '0;
        mq.delete();
        exp_drops = 0;
        last_rd = '0;
        @(negedge clk);
        RESET = 1'b0;
        Q_valid_in = 1'b0;
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_drops", 32'(drop_count), 0);
        chkw("mid_rst_data", rd_data, '0);
        wait_cyc(3);
        step(1, 31'd42, 4'b0, 32'd3, 0);
        step(0, '0, '0, '0, 1);
        chk("post_rst_empty", 32'(empty), 1);

        // Timestamp wrap on the 3-bit instance
        do_reset();
        wait_cyc(7);
        w_valid = 1'b1;
        Q_in = 31'd1;
        @(negedge clk);
        Q_in = 31'd2;
        @(negedge clk);
        w_valid = 1'b0;
        w_rd = 1'b1;
        @(negedge clk);
        chk("wrap_valid", 32'(w_rd_valid), 1);
        chkw("wrap_ts7", word_t'(w_rd_data), word_t'({4'b0, 3'd7, 31'd1}));
        @(negedge clk);
        w_rd = 1'b0;
        chkw("wrap_ts0", word_t'(w_rd_data), word_t'({4'b0, 3'd0, 31'd2}));
        chk("wrap_empty", 32'(w_empty), 1);
        chk("wrap_full", 32'(w_full), 0);
        chk("wrap_count", 32'(w_count), 0);
        chk("wrap_drops", 32'(w_drops), 0);

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_event_buffer.md
Name: q_event_buffer

Overview:
- Downstream of the Q extractor. Captures each Q value on its valid strobe.
- Tags each Q with a trigger timestamp and a per-channel ToT mask, and buffers the tagged words in a synchronous FIFO.
- The slow-control readout drains the FIFO over a rd_en/rd_valid interface.
- Counts events lost to FIFO overflow.

Parameters:
- Q_WIDTH, 31, width of the Q value from the extractor.
- TS_WIDTH, 32, width of the free-running timestamp counter.
- NCH, 4, number of ToT channels.
- DEPTH_LOG2, 4, log2 of FIFO depth (16 words).

Ports:
- clk  in  1  system clock (60 MHz).
- RESET  in  1  synchronous, active-high reset.
- Q_in  in  Q_WIDTH  Q value from extractor.
- Q_valid_in  in  1  one-cycle strobe, Q_in valid.
- tot_in  in  NCH  per-channel ToT bits from fir_trig.
- rd_en  in  1  read request, one word per asserted cycle.
- rd_data  out  NCH+TS_WIDTH+Q_WIDTH  event word {mask, ts, Q}, MSB first (67 bits at defaults).
- rd_valid  out  1  rd_data valid this cycle.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds 2^DEPTH_LOG2 words.
- count  out  DEPTH_LOG2+1  words held.
- drop_count  out  16  events dropped due to full; saturating.
- clear_drops  in  1  zeroes drop_count.

Behaviour:
- Reset (synchronous, RESET=1 at a clk edge): clears the following. Any partially captured event is discarded and no write occurs that cycle.
  - Timestamp counter = 0.
  - Accumulated mask = 0; armed = 1.
  - FIFO pointers = 0; count = 0.
  - Outputs: empty = 1, full = 0, rd_valid = 0, rd_data = 0, drop_count = 0.
- Timestamp: ts increments by 1 every cycle and wraps modulo 2^TS_WIDTH.
- Trigger tagging:
  - any_trig = OR of tot_in. A rising edge is judged against the registered previous value of any_trig, which is 0 after reset.
  - While armed, the first rising edge of any_trig latches ts into ts_lat and clears armed.
  - acc_mask |= tot_in every cycle.
- Capture, on a cycle with Q_valid_in=1:
  - word.mask = acc_mask | tot_in, including the current-cycle bits.
  - word.ts = ts_lat if not armed; otherwise the current ts. Q_valid_in without a prior trigger edge is tagged with the capture-cycle ts.
  - word.Q = Q_in.
  - Next cycle: acc_mask = 0 and armed = 1, regardless of whether the write succeeded.
  - A rising edge in the same cycle as Q_valid_in belongs to the current word; it does not arm-latch for the next word.
- Write: occurs when Q_valid_in=1 and full=0. full is judged on the pre-cycle state, so a write while full is dropped even if a read happens in the same cycle.
- Drop: when full=1 and Q_valid_in=1, drop_count increments and saturates at 16'hFFFF.
  - clear_drops has priority: drop_count = 0 next cycle even if a drop coincides.
- Read:
  - rd_en=1 and empty=0: pops the head word. rd_data is registered, valid on the next cycle with rd_valid=1.
  - rd_en while empty is ignored: rd_valid = 0, rd_data holds its last value.
  - On an empty FIFO, a simultaneous write and read performs only the write.
  - On a non-empty, non-full FIFO, a simultaneous write and read leaves count unchanged.
- count, empty and full are registered and reflect state after the cycle's operations.
- Pointers wrap modulo 2^DEPTH_LOG2. full/empty are derived from an extra pointer MSB.
- Latencies:
  - Q_valid_in to empty deassert: 1 cycle.
  - rd_en to rd_valid: 1 cycle.

Decomposition:
- Shared package holds:
  - Q_WIDTH, TS_WIDTH and NCH defaults.
  - The event-word field offsets and total width (MASK_LSB = TS_WIDTH+Q_WIDTH, TS_LSB = Q_WIDTH), so the readout decoder shares them.
- One sub-module: sync_fifo (parameterised width/depth, registered read port, count/full/empty). Tagging logic, timestamp and drop counter stay in q_event_buffer.

Test Plan:
- Tagging: reset, then tot_in=4'b0010 from cycle 10, tot_in=4'b0110 at cycle 12, Q_valid_in with Q_in=31'd1234 at cycle 20, rd_en at cycle 25 -> at cycle 26 rd_valid=1, rd_data = {4'b0110, 32'd10, 31'd1234}.
- Untriggered capture: Q_valid_in with Q_in=31'd7 at cycle 5 with tot_in=0 -> word {4'b0000, 32'd5, 31'd7}.
- Fill and overflow: 16 strobes -> full=1, count=16. 3 more strobes -> drop_count=3, count still 16. Pulse clear_drops -> drop_count=0.
- Full with simultaneous read and write: full, rd_en and Q_valid_in in the same cycle -> write dropped (drop_count +1), count=15.
- Read while empty: rd_en with empty=1 -> rd_valid stays 0, rd_data unchanged. Empty FIFO with simultaneous write and read -> count=1, rd_valid=0.
- Reset mid-operation and wrap: 5 words stored plus armed latch pending, then RESET for 1 cycle -> empty=1, count=0, drop_count=0, next Q_valid_in tagged with post-reset ts. Force ts to 32'hFFFF_FFFF -> next cycle ts=0.
